// File: rtl/led_trail_if.sv
// LED display bus between the pattern source and the led_trail stage:
// refresh request (enable/position) in, LED drive and head index out.
interface led_trail_if #(
  parameter int NUM_LEDS = 18
);
  logic                enable;
  logic [4:0]          position;
  logic [NUM_LEDS-1:0] LEDR;
  logic [4:0]          head;

  modport master (output enable, position, input  LEDR, head);
  modport slave  (input  enable, position, output LEDR, head);
endinterface

// File: rtl/led_trail.sv
// Comet-trail LED display: head LED held at full brightness, older LEDs fade via PWM.
// LED_TRAIL_DECAY_EN enables the fading trail; otherwise LEDR is a registered one-hot of head.
module led_trail #(
  parameter int NUM_LEDS  = 18,
  parameter int PWM_BITS  = 4,
  parameter int DECAY_DIV = 4
) (
  input logic        Clock,
  input logic        Resetn,
  led_trail_if.slave bus
);
  if (NUM_LEDS < 1 || NUM_LEDS > 32 || PWM_BITS < 1 || DECAY_DIV < 1) begin : g_bad_cfg
    $error("led_trail: illegal parameter set");
  end

  logic                accept;
  logic [4:0]          head_d, head_q;
  logic [NUM_LEDS-1:0] ledr;

  always_comb begin
    accept = bus.enable && ({1'b0, bus.position} < 6'(NUM_LEDS));
    head_d = accept ? bus.position : head_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) head_q <= '0;
    else         head_q <= head_d;
  end

  assign bus.head = head_q;
  assign bus.LEDR = ledr;

`ifdef LED_TRAIL_DECAY_EN
  localparam int LMAX = (1 << PWM_BITS) - 1;
  localparam int DW   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  logic [DW-1:0]       dec_cnt_d, dec_cnt_q;
  logic                tick;

  // Both counters free-run regardless of refresh activity.
  always_comb begin
    tick      = (dec_cnt_q == DW'(DECAY_DIV - 1));
    dec_cnt_d = tick ? '0 : dec_cnt_q + 1'b1;
    pwm_cnt_d = (pwm_cnt_q == PWM_BITS'(LMAX - 1)) ? '0 : pwm_cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dec_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [PWM_BITS-1:0] level_d, level_q;
    logic                led_d, led_q;
    logic                refresh;

    assign refresh = accept && (bus.position == 5'(i));

    // Refresh beats a coincident decay tick; decay saturates at zero.
    always_comb begin
      level_d = level_q;
      if (refresh)                     level_d = '1;
      else if (tick && level_q != '0)  level_d = level_q - 1'b1;
      led_d = (level_q > pwm_cnt_q);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        level_q <= '0;
        led_q   <= 1'b0;
      end else begin
        level_q <= level_d;
        led_q   <= led_d;
      end
    end

    assign ledr[i] = led_q;
  end
`else
  logic                seen_d, seen_q;
  logic [NUM_LEDS-1:0] ledr_d, ledr_q;

  // seen keeps LEDR dark until a first position is accepted, even though head resets to 0.
  always_comb begin
    seen_d = seen_q | accept;
    ledr_d = seen_q ? (NUM_LEDS'(1) << head_q) : '0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      seen_q <= 1'b0;
      ledr_q <= '0;
    end else begin
      seen_q <= seen_d;
      ledr_q <= ledr_d;
    end
  end

  assign ledr = ledr_q;
`endif
endmodule

// File: tb/tb_led_trail.sv
// Self-checking bench for led_trail; covers both the fading and the one-hot build.
module tb_led_trail;
  localparam int NL   = 18;
  localparam int PB   = 4;
  localparam int DD   = 4;
  localparam int LMAX = (1 << PB) - 1;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  led_trail_if #(.NUM_LEDS(NL)) bus ();

  led_trail #(.NUM_LEDS(NL), .PWM_BITS(PB), .DECAY_DIV(DD)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [NL-1:0] ledr;
    logic [4:0]    head;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            errors  = 0;
  logic [NL-1:0] obs_ledr;

  logic [NL-1:0] m_ledr;
  logic [4:0]    m_head;
  logic          m_seen;
  int            m_lvl[NL];
  int            m_pwm, m_dec;

  task automatic model_reset();
    m_ledr = '0; m_head = '0; m_seen = 1'b0; m_pwm = 0; m_dec = 0;
    for (int i = 0; i < NL; i++) m_lvl[i] = 0;
    sb.delete();
  endtask

  // Reference behaviour of one rising edge with the given inputs.
  task automatic model_step(input logic en, input logic [4:0] pos);
    logic          acc;
    logic [NL-1:0] nl;
    logic          tick;
    acc = en && (int'(pos) < NL);
`ifdef LED_TRAIL_DECAY_EN
    for (int i = 0; i < NL; i++) nl[i] = (m_lvl[i] > m_pwm);
    tick = (m_dec == DD - 1);
    for (int i = 0; i < NL; i++) begin
      if (acc && int'(pos) == i)     m_lvl[i] = LMAX;
      else if (tick && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
    end
    m_dec = tick ? 0 : m_dec + 1;
    m_pwm = (m_pwm == LMAX - 1) ? 0 : m_pwm + 1;
`else
    tick = 1'b0;
    nl   = '0;
    if (m_seen) nl[m_head] = 1'b1;
    if (acc) m_seen = 1'b1;
`endif
    m_ledr = nl;
    if (acc) m_head = pos;
  endtask

  task automatic cycle(input logic en, input logic [4:0] pos, input string tag);
    exp_t e;
    bus.enable   = en;
    bus.position = pos;
    model_step(en, pos);
    sb.push_back('{ledr: m_ledr, head: m_head});
    @(posedge Clock); #1;
    e        = sb.pop_front();
    obs_ledr = bus.LEDR;
    vectors++;
    if (bus.LEDR !== e.ledr || bus.head !== e.head) begin
      errors++;
      $display("FAIL %s: LEDR=%h head=%0d, expected LEDR=%h head=%0d",
               tag, bus.LEDR, bus.head, e.ledr, e.head);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    model_reset();
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.position = 5'd3;
    Resetn = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
      vectors++;
      if (bus.LEDR !== '0 || bus.head !== 5'd0) begin
        errors++;
        $display("FAIL reset_hold: LEDR=%h head=%0d, expected 0/0", bus.LEDR, bus.head);
      end
    end
    model_reset();
    Resetn = 1'b1;
    for (int c = 0; c < 31; c++) begin
      cycle(1'b1, 5'd3, "steady_sb");
      if (c >= 1) begin
        vectors++;
        if (obs_ledr[3] !== 1'b1 || bus.head !== 5'd3) begin
          errors++;
          $display("FAIL steady_head c=%0d: LEDR[3]=%b head=%0d, expected 1/3", c, obs_ledr[3], bus.head);
        end
      end
    end
  endtask

`ifdef LED_TRAIL_DECAY_EN
  task automatic test_fade();
    int highs, prev_highs;
    prev_highs = 99;
    highs      = 0;
    repeat (20) cycle(1'b1, 5'd3, "fade_hold");
    for (int j = 1; j <= 75; j++) begin
      cycle(1'b1, 5'd4, "fade_sb");
      if (obs_ledr[3]) highs++;
      if (j >= 2) begin
        vectors++;
        if (obs_ledr[4] !== 1'b1) begin
          errors++;
          $display("FAIL fade_new_head j=%0d: LEDR[4]=%b, expected 1", j, obs_ledr[4]);
        end
      end
      if (j >= 61) begin
        vectors++;
        if (obs_ledr[3] !== 1'b0) begin
          errors++;
          $display("FAIL fade_dark j=%0d: LEDR[3]=%b, expected 0", j, obs_ledr[3]);
        end
      end
      if (j % 15 == 0) begin
        vectors++;
        if (highs > prev_highs) begin
          errors++;
          $display("FAIL fade_monotone j=%0d: highs=%0d, expected <= %0d", j, highs, prev_highs);
        end
        prev_highs = highs;
        highs      = 0;
      end
    end
  endtask
`endif

  task automatic test_out_of_range();
    cycle(1'b1, 5'd5, "oor_set");
    for (int c = 0; c < 100; c++) begin
      cycle(1'b1, 5'd20, "oor_sb");
      vectors++;
      if (bus.head !== 5'd5 || (obs_ledr & ~(NL'(1) << 5)) !== '0) begin
        errors++;
        $display("FAIL oor_hold c=%0d: LEDR=%h head=%0d, expected head 5 and only bit 5", c, obs_ledr, bus.head);
      end
    end
    vectors++;
`ifdef LED_TRAIL_DECAY_EN
    if (obs_ledr !== '0) begin
      errors++;
      $display("FAIL oor_fade: LEDR=%h, expected 0", obs_ledr);
    end
`else
    if (obs_ledr !== 18'h00020) begin
      errors++;
      $display("FAIL oor_onehot: LEDR=%h, expected 00020", obs_ledr);
    end
`endif
  endtask

  task automatic test_enable_gating();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      cycle(1'b0, 5'd7, "gate_sb");
      vectors++;
      if (obs_ledr !== '0 || bus.head !== 5'd0) begin
        errors++;
        $display("FAIL gate c=%0d: LEDR=%h head=%0d, expected 0/0", c, obs_ledr, bus.head);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 5'd2, "async_set");
    repeat (20) cycle(1'b1, 5'd31, "async_fade");
    #3;
    Resetn = 1'b0;
    #1;
    vectors++;
    if (bus.LEDR !== '0 || bus.head !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: LEDR=%h head=%0d, expected 0/0", bus.LEDR, bus.head);
    end
    @(posedge Clock); #1;
    model_reset();
    Resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b1, 5'd3, "b2b_a");
    cycle(1'b1, 5'd4, "b2b_b");
    vectors++;
`ifdef LED_TRAIL_DECAY_EN
    if (obs_ledr[3] !== 1'b1) begin
`else
    if (obs_ledr !== 18'h00008) begin
`endif
      errors++;
      $display("FAIL b2b_first: LEDR=%h, expected LED 3 lit", obs_ledr);
    end
    cycle(1'b0, 5'd0, "b2b_c");
    vectors++;
`ifdef LED_TRAIL_DECAY_EN
    if (obs_ledr[4] !== 1'b1 || obs_ledr[3] !== 1'b1) begin
`else
    if (obs_ledr !== 18'h00010) begin
`endif
      errors++;
      $display("FAIL b2b_second: LEDR=%h, expected LED 4 lit", obs_ledr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++)
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), "random");
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.position = '0;
    model_reset();
    test_reset();
`ifdef LED_TRAIL_DECAY_EN
    test_fade();
`endif
    test_out_of_range();
    test_enable_gating();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
